// File: rtl/pong_text_pkg.sv
// Shared glyph encoding, message FSM states and the message ROM for the pong text row.
package pong_text_pkg;

  localparam int unsigned GlyphW = 26;
  localparam int unsigned GlyphH = 40;

  localparam logic [4:0] CharP     = 5'd10;
  localparam logic [4:0] CharO     = 5'd11;
  localparam logic [4:0] CharN     = 5'd12;
  localparam logic [4:0] CharG     = 5'd13;
  localparam logic [4:0] CharW     = 5'd14;
  localparam logic [4:0] CharI     = 5'd15;
  localparam logic [4:0] CharBlank = 5'd31;

  typedef enum logic [1:0] {
    STitle = 2'd0,
    SScore = 2'd1,
    SFlash = 2'd2,
    SWin   = 2'd3
  } msg_state_e;

  // Only one digit glyph per score, so 10-15 show as 9.
  function automatic logic [4:0] digit_glyph(input logic [3:0] v);
    return (v > 4'd9) ? 5'd9 : {1'b0, v};
  endfunction

  function automatic logic [4:0] msg_char(input msg_state_e st, input logic winner,
                                          input logic [3:0] sl, input logic [3:0] sr,
                                          input logic [2:0] slot);
    logic [4:0] c;
    c = CharBlank;
    case (st)
      STitle: begin
        case (slot)
          3'd0: c = CharP;
          3'd1: c = CharO;
          3'd2: c = CharN;
          3'd3: c = CharG;
          default: c = CharBlank;
        endcase
      end
      SScore, SFlash: begin
        if (slot == 3'd0) c = digit_glyph(sl);
        else if (slot == 3'd3) c = digit_glyph(sr);
      end
      SWin: begin
        case (slot)
          3'd0: c = CharP;
          3'd1: c = winner ? 5'd2 : 5'd1;
          3'd3: c = CharW;
          3'd4: c = CharI;
          3'd5: c = CharN;
          default: c = CharBlank;
        endcase
      end
      default: c = CharBlank;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_slot_decode.sv
// Combinational map from pixel (x, y) to character slot, geometric hit and slot origin.
module text_slot_decode
  import pong_text_pkg::*;
#(
  parameter logic [9:0]  TEXT_X     = 10'd224,
  parameter logic [9:0]  TEXT_Y     = 10'd20,
  parameter int unsigned PITCH_LOG2 = 5,
  parameter int unsigned NUM_SLOTS  = 6
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [2:0] slot,
  output logic       hit,
  output logic [9:0] start_x
);

  logic [9:0] dx;
  logic [9:0] slot_full;
  logic [9:0] offset;
  logic       in_cell;
  logic       in_row;
  logic       in_slots;

  // dx wraps when x < TEXT_X; the explicit x >= TEXT_X term masks that case.
  assign dx        = x - TEXT_X;
  assign slot_full = dx >> PITCH_LOG2;
  assign offset    = dx & ((10'd1 << PITCH_LOG2) - 10'd1);
  assign in_cell   = offset < 10'(GlyphW);
  assign in_row    = (y >= TEXT_Y) && (y < TEXT_Y + 10'(GlyphH));
  assign in_slots  = slot_full < 10'(NUM_SLOTS);

  assign hit     = (x >= TEXT_X) && in_slots && in_cell && in_row;
  assign slot    = slot_full[2:0];
  assign start_x = TEXT_X + (slot_full << PITCH_LOG2);

endmodule

// File: rtl/text_overlay_ctrl.sv
// Frame-synchronous message sequencer for the pong text row; drives one shared glyph renderer.
module text_overlay_ctrl
  import pong_text_pkg::*;
#(
  parameter logic [9:0]  TEXT_X       = 10'd224,
  parameter logic [9:0]  TEXT_Y       = 10'd20,
  parameter int unsigned PITCH_LOG2   = 5,
  parameter int unsigned NUM_SLOTS    = 6,
  parameter logic [5:0]  FLASH_FRAMES = 6'd48,
  parameter int unsigned BLINK_LOG2   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       glyph_en,
  output logic [4:0] glyph_code,
  output logic [9:0] glyph_start_x,
  output logic [9:0] glyph_start_y,
  output logic [1:0] msg_state
);

  msg_state_e state_q;
  logic [3:0] lat_l_q;
  logic [3:0] lat_r_q;
  logic       winner_q;
  logic [5:0] flash_cnt_q;
  logic [7:0] frame_cnt_q;

  logic [2:0] slot;
  logic       geom_hit;
  logic [9:0] slot_start_x;
  logic [4:0] ch;
  logic       char_hit;
  logic       blink;
  logic       scores_changed;
  logic       is_idle;
  logic       is_over;

  text_slot_decode #(
    .TEXT_X     (TEXT_X),
    .TEXT_Y     (TEXT_Y),
    .PITCH_LOG2 (PITCH_LOG2),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_decode (
    .x       (x),
    .y       (y),
    .slot    (slot),
    .hit     (geom_hit),
    .start_x (slot_start_x)
  );

  always_comb begin
    ch             = msg_char(state_q, winner_q, lat_l_q, lat_r_q, slot);
    char_hit       = geom_hit && (ch != CharBlank);
    blink          = frame_cnt_q[BLINK_LOG2];
    scores_changed = (score_l != lat_l_q) || (score_r != lat_r_q);
    is_idle        = (game_state == 2'd0);
    is_over        = (game_state == 2'd2);
  end

  assign msg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= STitle;
      lat_l_q       <= '0;
      lat_r_q       <= '0;
      winner_q      <= 1'b0;
      flash_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      glyph_en      <= 1'b0;
      glyph_code    <= '0;
      glyph_start_x <= '0;
      glyph_start_y <= '0;
    end else begin
      // Pixel decode always uses the pre-tick state, even on a tick cycle.
      glyph_en      <= char_hit && !((state_q == SFlash) && blink);
      glyph_code    <= char_hit ? ch : CharBlank;
      glyph_start_x <= char_hit ? slot_start_x : 10'd0;
      glyph_start_y <= char_hit ? TEXT_Y : 10'd0;

      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        lat_l_q     <= score_l;
        lat_r_q     <= score_r;
        if (is_idle) begin
          state_q <= STitle;
        end else if (is_over) begin
          if (state_q != SWin) winner_q <= (score_l < score_r);
          state_q <= SWin;
        end else begin
          case (state_q)
            STitle: state_q <= SScore;
            SScore: begin
              if (scores_changed) begin
                state_q     <= SFlash;
                flash_cnt_q <= FLASH_FRAMES;
              end
            end
            SFlash: begin
              if (scores_changed) begin
                flash_cnt_q <= FLASH_FRAMES;
              end else if (flash_cnt_q <= 6'd1) begin
                state_q     <= SScore;
                flash_cnt_q <= '0;
              end else begin
                flash_cnt_q <= flash_cnt_q - 6'd1;
              end
            end
            SWin: state_q <= SScore;
            default: state_q <= STitle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl: title, score, flash/blink, clamp, winner and reset cases.
module tb_text_overlay_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [1:0] game_state;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [9:0] x;
  logic [9:0] y;
  logic       glyph_en;
  logic [4:0] glyph_code;
  logic [9:0] glyph_start_x;
  logic [9:0] glyph_start_y;
  logic [1:0] msg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] fc;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .game_state    (game_state),
    .score_l       (score_l),
    .score_r       (score_r),
    .x             (x),
    .y             (y),
    .glyph_en      (glyph_en),
    .glyph_code    (glyph_code),
    .glyph_start_x (glyph_start_x),
    .glyph_start_y (glyph_start_y),
    .msg_state     (msg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    x = 10'd0;
    y = 10'd0;
    step();
    frame_tick = 1'b0;
    fc = fc + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; game_state = 2'd0;
    score_l = 4'd0; score_r = 4'd0; x = 10'd224; y = 10'd30;
    step();
    step();
    checks++;
    if ({glyph_en, glyph_code, glyph_start_x, glyph_start_y, msg_state} !== 28'd0) begin
      errors++;
      $display("FAIL reset: en=%0d code=%0d sx=%0d sy=%0d st=%0d, want all 0",
               glyph_en, glyph_code, glyph_start_x, glyph_start_y, msg_state);
    end
    reset = 1'b0;
    fc = 8'd0;
  endtask

  task automatic test_title();
    int xs[6] = '{223, 224, 224, 224, 224, 249};
    int ys[6] = '{30, 19, 20, 59, 60, 59};
    logic en_t[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    y = 10'd30;
    for (int xi = 224; xi <= 415; xi++) begin
      int slot;
      int off;
      logic exp_en;
      logic [4:0] exp_code;
      logic [9:0] exp_sx;
      logic [9:0] exp_sy;
      x = 10'(xi);
      step();
      slot = (xi - 224) / 32;
      off = (xi - 224) % 32;
      exp_en = (slot < 4) && (off < 26);
      exp_code = exp_en ? 5'(10 + slot) : 5'd31;
      exp_sx = exp_en ? 10'(224 + 32 * slot) : 10'd0;
      exp_sy = exp_en ? 10'd20 : 10'd0;
      checks++;
      if (glyph_en !== exp_en || glyph_code !== exp_code || glyph_start_x !== exp_sx ||
          glyph_start_y !== exp_sy) begin
        errors++;
        $display("FAIL title x=%0d: en=%0d code=%0d sx=%0d sy=%0d, want %0d %0d %0d %0d", xi,
                 glyph_en, glyph_code, glyph_start_x, glyph_start_y,
                 exp_en, exp_code, exp_sx, exp_sy);
      end
    end
    for (int i = 0; i < 6; i++) begin
      x = 10'(xs[i]);
      y = 10'(ys[i]);
      step();
      checks++;
      if (glyph_en !== en_t[i] || glyph_code !== (en_t[i] ? 5'd10 : 5'd31)) begin
        errors++;
        $display("FAIL title_edge x=%0d y=%0d: en=%0d code=%0d, want en=%0d", xs[i], ys[i],
                 glyph_en, glyph_code, en_t[i]);
      end
    end
  endtask

  task automatic test_play();
    int xs[5] = '{224, 256, 288, 320, 352};
    logic en_t[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] code_t[5] = '{5'd3, 5'd31, 5'd31, 5'd5, 5'd31};
    logic [9:0] sx_t[5] = '{10'd224, 10'd0, 10'd0, 10'd320, 10'd0};
    game_state = 2'd1; score_l = 4'd3; score_r = 4'd5;
    tick();
    checks++;
    if (msg_state !== 2'd1) begin
      errors++;
      $display("FAIL play_enter: msg_state=%0d, want 1", msg_state);
    end
    tick();
    checks++;
    if (msg_state !== 2'd1) begin
      errors++;
      $display("FAIL play_hold: msg_state=%0d, want 1", msg_state);
    end
    y = 10'd30;
    for (int i = 0; i < 5; i++) begin
      x = 10'(xs[i]);
      step();
      checks++;
      if (glyph_en !== en_t[i] || glyph_code !== code_t[i] || glyph_start_x !== sx_t[i]) begin
        errors++;
        $display("FAIL play_slot x=%0d: en=%0d code=%0d sx=%0d, want %0d %0d %0d", xs[i],
                 glyph_en, glyph_code, glyph_start_x, en_t[i], code_t[i], sx_t[i]);
      end
    end
  endtask

  task automatic test_flash();
    score_l = 4'd4;
    tick();
    checks++;
    if (msg_state !== 2'd2) begin
      errors++;
      $display("FAIL flash_enter: msg_state=%0d, want 2", msg_state);
    end
    for (int i = 1; i <= 48; i++) begin
      logic [1:0] exp_st;
      x = 10'd224;
      y = 10'd30;
      step();
      checks++;
      if (glyph_en !== ~fc[3] || glyph_code !== 5'd4) begin
        errors++;
        $display("FAIL flash_blink frame %0d: en=%0d code=%0d, want en=%0d code=4", i,
                 glyph_en, glyph_code, ~fc[3]);
      end
      tick();
      exp_st = (i < 48) ? 2'd2 : 2'd1;
      checks++;
      if (msg_state !== exp_st) begin
        errors++;
        $display("FAIL flash_len tick %0d: msg_state=%0d, want %0d", i, msg_state, exp_st);
      end
    end
  endtask

  task automatic test_clamp();
    score_r = 4'd12;
    tick();
    x = 10'd320;
    y = 10'd30;
    step();
    checks++;
    if (msg_state !== 2'd2 || glyph_code !== 5'd9 || glyph_start_x !== 10'd320 ||
        glyph_en !== ~fc[3]) begin
      errors++;
      $display("FAIL clamp: st=%0d code=%0d sx=%0d en=%0d, want 2 9 320 %0d", msg_state,
               glyph_code, glyph_start_x, glyph_en, ~fc[3]);
    end
  endtask

  task automatic test_win();
    logic [4:0] code_t[6] = '{5'd10, 5'd1, 5'd31, 5'd14, 5'd15, 5'd12};
    game_state = 2'd2; score_l = 4'd7; score_r = 4'd7;
    tick();
    checks++;
    if (msg_state !== 2'd3) begin
      errors++;
      $display("FAIL win_enter: msg_state=%0d, want 3", msg_state);
    end
    y = 10'd30;
    for (int i = 0; i < 6; i++) begin
      logic exp_en;
      logic [9:0] exp_sx;
      exp_en = (code_t[i] != 5'd31);
      exp_sx = exp_en ? 10'(224 + 32 * i) : 10'd0;
      x = 10'(224 + 32 * i + 5);
      step();
      checks++;
      if (glyph_en !== exp_en || glyph_code !== code_t[i] || glyph_start_x !== exp_sx) begin
        errors++;
        $display("FAIL win_slot %0d: en=%0d code=%0d sx=%0d, want %0d %0d %0d", i, glyph_en,
                 glyph_code, glyph_start_x, exp_en, code_t[i], exp_sx);
      end
    end
    // Winner must stay latched from entry even if scores move while OVER.
    score_l = 4'd2; score_r = 4'd9;
    tick();
    x = 10'd256; y = 10'd30;
    step();
    checks++;
    if (glyph_code !== 5'd1) begin
      errors++;
      $display("FAIL win_hold: code=%0d, want 1", glyph_code);
    end
    // IDLE tick coincident with a slot-3 pixel: that pixel still shows 'W'.
    game_state = 2'd0; frame_tick = 1'b1; x = 10'd320; y = 10'd30;
    step();
    frame_tick = 1'b0;
    fc = fc + 8'd1;
    checks++;
    if (glyph_code !== 5'd14 || glyph_en !== 1'b1 || msg_state !== 2'd0) begin
      errors++;
      $display("FAIL win_to_idle: code=%0d en=%0d st=%0d, want 14 1 0", glyph_code,
               glyph_en, msg_state);
    end
    game_state = 2'd1;
    tick();
    game_state = 2'd2; score_l = 4'd3; score_r = 4'd8;
    tick();
    x = 10'd256; y = 10'd30;
    step();
    checks++;
    if (msg_state !== 2'd3 || glyph_code !== 5'd2) begin
      errors++;
      $display("FAIL win_p2: st=%0d code=%0d, want 3 2", msg_state, glyph_code);
    end
  endtask

  task automatic test_reset_mid();
    game_state = 2'd1;
    tick();
    score_l = 4'd4;
    tick();
    checks++;
    if (msg_state !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre: msg_state=%0d, want 2", msg_state);
    end
    x = 10'd230; y = 10'd30; reset = 1'b1;
    step();
    checks++;
    if ({glyph_en, glyph_code, glyph_start_x, glyph_start_y, msg_state} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset: en=%0d code=%0d sx=%0d sy=%0d st=%0d, want all 0",
               glyph_en, glyph_code, glyph_start_x, glyph_start_y, msg_state);
    end
    reset = 1'b0;
    fc = 8'd0;
    x = 10'd231;
    step();
    checks++;
    if (glyph_en !== 1'b1 || glyph_code !== 5'd10 || glyph_start_x !== 10'd224 ||
        glyph_start_y !== 10'd20 || msg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_title: en=%0d code=%0d sx=%0d sy=%0d st=%0d, want 1 10 224 20 0",
               glyph_en, glyph_code, glyph_start_x, glyph_start_y, msg_state);
    end
  endtask

  initial begin
    fc = 8'd0;
    test_reset();
    test_title();
    test_play();
    test_flash();
    test_clamp();
    test_win();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end

endmodule
